// File: rtl/w0rm_core_pkg.sv
// Shared definitions for the w0rm core register file.
// Holds the address-width derivation used by the top level, the interface and the bench.
// Pure constants and constant functions only; no logic lives here.
package w0rm_core_pkg;

  // Read latency choices for the SINGLE_CYCLE parameter.
  localparam bit LAT_TWO_CYCLE = 1'b0;
  localparam bit LAT_ONE_CYCLE = 1'b1;

  // Ceiling log2; clog2(1) is 0, clog2(4) is 2, clog2(5) is 3.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Address width for a register count; never narrower than one bit.
  function automatic int calc_addr_width(input int num_registers);
    return (clog2(num_registers) < 1) ? 1 : clog2(num_registers);
  endfunction

endpackage

// File: rtl/w0rm_core_register_file_if.sv
// Bus bundle for the register file: one write port and two read ports.
// Master drives addresses, write strobe and write data; slave returns read data.
// No handshake: every field is sampled or updated on every clock edge.
interface w0rm_core_register_file_if
  import w0rm_core_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = calc_addr_width(4)
);
  logic [ADDR_WIDTH-1:0] port_read0_addr;
  logic [DATA_WIDTH-1:0] port_read0_data;
  logic [ADDR_WIDTH-1:0] port_read1_addr;
  logic [DATA_WIDTH-1:0] port_read1_data;
  logic [ADDR_WIDTH-1:0] port_write_addr;
  logic                  port_write_enable;
  logic [DATA_WIDTH-1:0] port_write_data;

  modport master (
    output port_read0_addr, port_read1_addr,
    output port_write_addr, port_write_enable, port_write_data,
    input  port_read0_data, port_read1_data
  );

  modport slave (
    input  port_read0_addr, port_read1_addr,
    input  port_write_addr, port_write_enable, port_write_data,
    output port_read0_data, port_read1_data
  );
endinterface

// File: rtl/w0rm_core_regfile_read_port.sv
// One read port: range check, write-first bypass, then a 1- or 2-stage output pipeline.
// Latency is 1 edge when SINGLE_CYCLE=1, otherwise 2 edges, fully pipelined.
// Never stalls; a new address is accepted every cycle.
module w0rm_core_regfile_read_port
  import w0rm_core_pkg::*;
#(
  parameter bit SINGLE_CYCLE  = LAT_ONE_CYCLE,
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 2,
  parameter int NUM_REGISTERS = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [ADDR_WIDTH-1:0]                  i_rd_addr,
  input  logic                                   i_wr_en,
  input  logic [ADDR_WIDTH-1:0]                  i_wr_addr,
  input  logic [DATA_WIDTH-1:0]                  i_wr_data,
  input  logic [NUM_REGISTERS-1:0][DATA_WIDTH-1:0] i_regs,
  output logic [DATA_WIDTH-1:0]                  o_rd_data
);
  logic                  w_in_range;
  logic                  w_bypass;
  logic [DATA_WIDTH-1:0] w_next;
  logic [DATA_WIDTH-1:0] r_stage1;

  // Out-of-range addresses read as zero, which also suppresses any bypass to them.
  assign w_in_range = 32'(i_rd_addr) < 32'(NUM_REGISTERS);
  assign w_bypass   = i_wr_en && (i_wr_addr == i_rd_addr);

  // Select the value to capture: zero, the word being written this edge, or stored contents.
  always_comb begin
    w_next = '0;
    if (w_in_range) begin
      if (w_bypass) begin
        w_next = i_wr_data;
      end else begin
        w_next = i_regs[i_rd_addr];
      end
    end
  end

  // First output stage, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage1 <= '0;
    end else begin
      r_stage1 <= w_next;
    end
  end

  generate
    if (SINGLE_CYCLE) begin : g_one_stage
      assign o_rd_data = r_stage1;
    end else begin : g_two_stage
      logic [DATA_WIDTH-1:0] r_stage2;
      // Second output stage for the two-cycle read option.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_stage2 <= '0;
        end else begin
          r_stage2 <= r_stage1;
        end
      end
      assign o_rd_data = r_stage2;
    end
  endgenerate
endmodule

// File: rtl/w0rm_core_register_file.sv
// Register file with one write port and two independent read ports.
// Read latency 1 (SINGLE_CYCLE=1) or 2 edges; writes take effect at the edge they are presented.
// No backpressure: one write and two reads are accepted every cycle.
module w0rm_core_register_file
  import w0rm_core_pkg::*;
#(
  parameter bit SINGLE_CYCLE  = LAT_ONE_CYCLE,
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_REGISTERS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  w0rm_core_register_file_if.slave i_rf
);
  localparam int ADDR_WIDTH = calc_addr_width(NUM_REGISTERS);

  logic [NUM_REGISTERS-1:0][DATA_WIDTH-1:0] r_regs;
  logic                                     w_wr_ok;

  // Writes beyond the last register are dropped.
  assign w_wr_ok = i_rf.port_write_enable &&
                   (32'(i_rf.port_write_addr) < 32'(NUM_REGISTERS));

  // Register storage; reset clears everything and overrides a concurrent write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_regs <= '0;
    end else if (w_wr_ok) begin
      r_regs[i_rf.port_write_addr] <= i_rf.port_write_data;
    end
  end

  w0rm_core_regfile_read_port #(
    .SINGLE_CYCLE  (SINGLE_CYCLE),
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDR_WIDTH    (ADDR_WIDTH),
    .NUM_REGISTERS (NUM_REGISTERS)
  ) u_read0 (
    .clk       (clk),
    .reset     (reset),
    .i_rd_addr (i_rf.port_read0_addr),
    .i_wr_en   (i_rf.port_write_enable),
    .i_wr_addr (i_rf.port_write_addr),
    .i_wr_data (i_rf.port_write_data),
    .i_regs    (r_regs),
    .o_rd_data (i_rf.port_read0_data)
  );

  w0rm_core_regfile_read_port #(
    .SINGLE_CYCLE  (SINGLE_CYCLE),
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDR_WIDTH    (ADDR_WIDTH),
    .NUM_REGISTERS (NUM_REGISTERS)
  ) u_read1 (
    .clk       (clk),
    .reset     (reset),
    .i_rd_addr (i_rf.port_read1_addr),
    .i_wr_en   (i_rf.port_write_enable),
    .i_wr_addr (i_rf.port_write_addr),
    .i_wr_data (i_rf.port_write_data),
    .i_regs    (r_regs),
    .o_rd_data (i_rf.port_read1_data)
  );
endmodule

// File: tb/tb_w0rm_core_register_file.sv
// Bench for the register file: three instances (4 regs/latency 1, 4 regs/latency 2, 5 regs/latency 1).
// Stimulus pushes expected read data tagged with the cycle it must appear in.
// A monitor on the falling edge pops and compares those entries.
module tb_w0rm_core_register_file;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;

  w0rm_core_register_file_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) ifa ();
  w0rm_core_register_file_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) ifb ();
  w0rm_core_register_file_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) ifc ();

  w0rm_core_register_file #(.SINGLE_CYCLE(1'b1), .DATA_WIDTH(8), .NUM_REGISTERS(4)) dut_a (
    .clk(clk), .reset(rst_a), .i_rf(ifa.slave));
  w0rm_core_register_file #(.SINGLE_CYCLE(1'b0), .DATA_WIDTH(8), .NUM_REGISTERS(4)) dut_b (
    .clk(clk), .reset(rst_b), .i_rf(ifb.slave));
  w0rm_core_register_file #(.SINGLE_CYCLE(1'b1), .DATA_WIDTH(8), .NUM_REGISTERS(5)) dut_c (
    .clk(clk), .reset(rst_c), .i_rf(ifc.slave));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    int         dut;
    int         port;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] got;

  task automatic expect_rd(input int dut, input int port, input int lat, input logic [7:0] v);
    exp_t e;
    e.due  = cyc + lat;
    e.dut  = dut;
    e.port = port;
    e.exp  = v;
    sb.push_back(e);
  endtask

  function automatic logic [7:0] dut_out(input int dut, input int port);
    case (dut)
      0:       return (port == 0) ? ifa.port_read0_data : ifa.port_read1_data;
      1:       return (port == 0) ? ifb.port_read0_data : ifb.port_read1_data;
      default: return (port == 0) ? ifc.port_read0_data : ifc.port_read1_data;
    endcase
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // Monitor: compare every scoreboard entry that falls due this cycle.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due <= cyc) begin
          checks++;
          got = dut_out(sb[i].dut, sb[i].port);
          if (sb[i].due < cyc) begin
            errors++;
            $display("FAIL missed_check dut%0d port%0d due=%0d now=%0d", sb[i].dut, sb[i].port, sb[i].due, cyc);
          end else if (got !== sb[i].exp) begin
            errors++;
            $display("FAIL rd_data dut%0d port%0d cyc=%0d got=%02h exp=%02h",
                     sb[i].dut, sb[i].port, cyc, got, sb[i].exp);
          end
          sb.delete(i);
        end
      end
    end
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    ifa.port_read0_addr = '0; ifa.port_read1_addr = '0; ifa.port_write_addr = '0;
    ifa.port_write_enable = 1'b0; ifa.port_write_data = '0;
    ifb.port_read0_addr = '0; ifb.port_read1_addr = '0; ifb.port_write_addr = '0;
    ifb.port_write_enable = 1'b0; ifb.port_write_data = '0;
    ifc.port_read0_addr = '0; ifc.port_read1_addr = '0; ifc.port_write_addr = '0;
    ifc.port_write_enable = 1'b0; ifc.port_write_data = '0;
    step(); step();

    // Reset edge with a concurrent write: outputs clear, write is lost.
    ifa.port_write_enable = 1'b1; ifa.port_write_addr = 2'd2; ifa.port_write_data = 8'hFF;
    ifa.port_read0_addr = 2'd2; ifa.port_read1_addr = 2'd3;
    expect_rd(0, 0, 1, 8'h00); expect_rd(0, 1, 1, 8'h00);
    expect_rd(1, 0, 1, 8'h00); expect_rd(1, 1, 1, 8'h00);
    step();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // First reads after reset return zero for unwritten registers.
    ifa.port_write_enable = 1'b0;
    expect_rd(0, 0, 1, 8'h00); expect_rd(0, 1, 1, 8'h00);
    step();

    // Write 11,22,33,44 to registers 0..3.
    for (int i = 0; i < 4; i++) begin
      ifa.port_write_enable = 1'b1;
      ifa.port_write_addr   = 2'(i);
      ifa.port_write_data   = 8'(17 * (i + 1));
      step();
    end
    ifa.port_write_enable = 1'b0;

    // Read-back sweep: port 0 ascending, port 1 descending.
    for (int i = 0; i < 4; i++) begin
      ifa.port_read0_addr = 2'(i);
      ifa.port_read1_addr = 2'(3 - i);
      expect_rd(0, 0, 1, 8'(17 * (i + 1)));
      expect_rd(0, 1, 1, 8'(17 * (4 - i)));
      step();
    end

    // Write with enable low is ignored, including by the bypass path.
    ifa.port_write_enable = 1'b0; ifa.port_write_addr = 2'd2; ifa.port_write_data = 8'hAA;
    ifa.port_read0_addr = 2'd2;
    expect_rd(0, 0, 1, 8'h33);
    step();
    expect_rd(0, 0, 1, 8'h33);
    step();

    // Collision: both ports read the register being written.
    ifa.port_write_enable = 1'b1; ifa.port_write_addr = 2'd1; ifa.port_write_data = 8'h5A;
    ifa.port_read0_addr = 2'd1; ifa.port_read1_addr = 2'd1;
    expect_rd(0, 0, 1, 8'h5A); expect_rd(0, 1, 1, 8'h5A);
    step();
    ifa.port_write_enable = 1'b0;
    expect_rd(0, 0, 1, 8'h5A); expect_rd(0, 1, 1, 8'h5A);
    step();
    ifa.port_read0_addr = 2'd0; ifa.port_read1_addr = 2'd3;
    expect_rd(0, 0, 1, 8'h11); expect_rd(0, 1, 1, 8'h44);
    step();

    // Load A1..A4, then reset with a concurrent write.
    for (int i = 0; i < 4; i++) begin
      ifa.port_write_enable = 1'b1;
      ifa.port_write_addr   = 2'(i);
      ifa.port_write_data   = 8'(8'hA1 + i);
      step();
    end
    rst_a = 1'b1;
    ifa.port_write_enable = 1'b1; ifa.port_write_addr = 2'd0; ifa.port_write_data = 8'h77;
    ifa.port_read0_addr = 2'd0; ifa.port_read1_addr = 2'd1;
    expect_rd(0, 0, 1, 8'h00); expect_rd(0, 1, 1, 8'h00);
    step();
    rst_a = 1'b0;
    ifa.port_write_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ifa.port_read0_addr = 2'(i);
      ifa.port_read1_addr = 2'(i);
      expect_rd(0, 0, 1, 8'h00); expect_rd(0, 1, 1, 8'h00);
      step();
    end

    // Two-cycle instance: register 3 = 44 appears exactly two edges after its address.
    ifb.port_write_enable = 1'b1; ifb.port_write_addr = 2'd3; ifb.port_write_data = 8'h44;
    ifb.port_read0_addr = 2'd0; ifb.port_read1_addr = 2'd0;
    step();
    ifb.port_write_enable = 1'b0;
    ifb.port_read0_addr = 2'd3; ifb.port_read1_addr = 2'd3;
    expect_rd(1, 0, 1, 8'h00);
    expect_rd(1, 0, 2, 8'h44); expect_rd(1, 1, 2, 8'h44);
    step();
    ifb.port_read0_addr = 2'd0;
    expect_rd(1, 0, 2, 8'h00);
    ifb.port_write_enable = 1'b1; ifb.port_write_addr = 2'd2; ifb.port_write_data = 8'h5A;
    ifb.port_read1_addr = 2'd2;
    expect_rd(1, 1, 2, 8'h5A);
    step();
    ifb.port_write_enable = 1'b0;
    ifb.port_read1_addr = 2'd0;
    expect_rd(1, 1, 2, 8'h00);
    step();

    // Five-register instance: register 4 works, addresses 6 and 7 are out of range.
    ifc.port_write_enable = 1'b1; ifc.port_write_addr = 3'd4; ifc.port_write_data = 8'h55;
    step();
    ifc.port_write_addr = 3'd6; ifc.port_write_data = 8'hEE;
    ifc.port_read0_addr = 3'd6;
    expect_rd(2, 0, 1, 8'h00);
    step();
    ifc.port_write_addr = 3'd7; ifc.port_write_data = 8'hEE;
    ifc.port_read0_addr = 3'd4; ifc.port_read1_addr = 3'd7;
    expect_rd(2, 0, 1, 8'h55); expect_rd(2, 1, 1, 8'h00);
    step();
    ifc.port_write_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ifc.port_read0_addr = 3'(i);
      ifc.port_read1_addr = 3'(4 - i);
      expect_rd(2, 0, 1, (i == 4) ? 8'h55 : 8'h00);
      expect_rd(2, 1, 1, (i == 0) ? 8'h55 : 8'h00);
      step();
    end

    // Drain, then flag anything the monitor never reached.
    repeat (4) step();
    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL unchecked dut%0d port%0d due=%0d now=%0d", sb[0].dut, sb[0].port, sb[0].due, cyc);
      void'(sb.pop_front());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/w0rm_core_register_file.md
W0RM_CORE_REGISTER_FILE -- requirements
Module: w0rm_core_register_file

Interface
REQ-001 Clocking SHALL be: one clock; reset is synchronous and active-high.
REQ-002 Parameter SINGLE_CYCLE, default 1, read latency select: 1 = one-cycle registered read, 0 = two-cycle read.
REQ-003 Parameter DATA_WIDTH, default 8, register width in bits; legal values 1 and up.
REQ-004 Parameter NUM_REGISTERS, default 4, register count; legal values 2 and up.
REQ-005 Derived constant ADDR_WIDTH SHALL equal ceil(log2(NUM_REGISTERS)), e.g. 2 for 4 registers, 3 for 5 registers.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 port_read0_addr  input  ADDR_WIDTH  read port 0 address.
REQ-009 port_read0_data  output  DATA_WIDTH  read port 0 data.
REQ-010 port_read1_addr  input  ADDR_WIDTH  read port 1 address.
REQ-011 port_read1_data  output  DATA_WIDTH  read port 1 data.
REQ-012 port_write_addr  input  ADDR_WIDTH  write address.
REQ-013 port_write_enable  input  1  write strobe, active high.
REQ-014 port_write_data  input  DATA_WIDTH  write data.

Function
REQ-015 Storage SHALL be NUM_REGISTERS general registers of DATA_WIDTH bits; register 0 is an ordinary writable register, not hardwired.
REQ-016 When port_write_enable=1 at a rising clk edge, register[port_write_addr] SHALL take port_write_data at that edge.
REQ-017 Writes SHALL be ignored when port_write_enable=0.
REQ-018 Writes SHALL be ignored when port_write_addr >= NUM_REGISTERS.
REQ-019 With SINGLE_CYCLE=1, each read port SHALL register register[addr] at a rising edge and present it on its data output after that edge (latency 1); data does not follow a later address change until the next edge.
REQ-020 With SINGLE_CYCLE=0, each read port SHALL add a second output register stage (latency 2, fully pipelined, one new address accepted per cycle).
REQ-021 Write-first bypass: if a read port samples the address being written at the same edge, it SHALL capture port_write_data, not the old contents.
REQ-022 Reads at addresses >= NUM_REGISTERS SHALL return all zeros.
REQ-023 The two read ports SHALL be fully independent and may read the same or different addresses in the same cycle.
REQ-024 There SHALL be no stall or backpressure; every cycle accepts one write and two reads.

Reset
REQ-025 While reset=1 at a rising edge, all registers and all read pipeline stages SHALL clear to 0, and port_read0_data and port_read1_data SHALL read 0 after that edge.
REQ-026 A write presented in the same cycle as reset SHALL be discarded (reset wins).
REQ-027 After reset deasserts, the first read SHALL return 0 for any address not yet written.

Structure
REQ-028 The clog2 helper function and the ADDR_WIDTH derivation SHALL live in the shared package w0rm_core_pkg.
REQ-029 Each read port SHALL be one instance of sub-module w0rm_core_regfile_read_port, parameterised by latency, DATA_WIDTH and ADDR_WIDTH, containing the bypass mux, range check and output pipeline; the top level instantiates it twice.

Verification
REQ-030 Write then read back: DATA_WIDTH=8, NUM_REGISTERS=4, SINGLE_CYCLE=1; write 0x11, 0x22, 0x33, 0x44 to registers 0 to 3; then sweep port_read0_addr 0,1,2,3 on successive edges -> port_read0_data is 0x11, 0x22, 0x33, 0x44, each one cycle after its address.
REQ-031 Write-enable gating: write 0xAA to register 2 with enable=0 -> register 2 still reads its prior value.
REQ-032 Collision: write 0x5A to register 1 while both ports read register 1 -> both ports show 0x5A after the edge.
REQ-033 Reset: load all four registers, then assert reset for one cycle with a concurrent write -> both ports read 0x00 at every address afterwards.
REQ-034 Latency and range: with SINGLE_CYCLE=0, a read of register 3 holding 0x44 appears exactly two edges after the address is applied; with NUM_REGISTERS=5, a read at address 6 returns 0x00 and a write to address 6 changes no register.
